// File: rtl/sched_pkg.sv
// Shared types for the context scheduler: slot states, FSM states, event kinds
// and the PID width helper.
package sched_pkg;

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    READY   = 2'd1,
    RUNNING = 2'd2,
    BLOCKED = 2'd3
  } slotStateT;

  typedef enum logic [2:0] {
    OFF,
    RUN,
    SAVE,
    SELECT,
    DISPATCH,
    IDLE
  } fsmStateT;

  typedef enum logic [1:0] {
    EV_END,
    EV_IO,
    EV_QUANTUM
  } evTypeT;

  function automatic int pid_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set bit of readyMask at or after
// start, wrapping, so the slot just before start is the last candidate.
module rr_picker #(
  parameter int NPROC = 4,
  parameter int PID_W = 2
) (
  input  logic [NPROC-1:0] readyMask,
  input  logic [PID_W-1:0] start,
  output logic             found,
  output logic [PID_W-1:0] index
);

  logic [PID_W:0] cand;

  // Walk from the farthest candidate back so the nearest ready slot wins.
  always_comb begin
    found = 1'b0;
    index = '0;
    cand  = '0;
    for (int k = NPROC - 1; k >= 0; k--) begin
      cand = {1'b0, start} + (PID_W + 1)'(k);
      if (cand >= (PID_W + 1)'(NPROC)) cand = cand - (PID_W + 1)'(NPROC);
      if (readyMask[cand]) begin
        found = 1'b1;
        index = cand[PID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/context_scheduler.sv
// Round-robin process scheduler with per-slot saved PC and quantum counting.
// Optional SCHED_SWITCH_COUNT_EN adds saturating switch/preemption counters.
module context_scheduler
  import sched_pkg::*;
#(
  parameter int NPROC       = 4,
  parameter int PC_W        = 32,
  parameter int QUANTUM     = 16,
  parameter int QCNT_W      = 8,
  parameter int BASE_STRIDE = 2048,
  localparam int PID_W      = pid_width(NPROC)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              step,
  input  logic [PC_W-1:0]   pc,
  input  logic              io_req,
  input  logic              proc_end,
  input  logic [NPROC-1:0]  io_done,
  input  logic              proc_create,
  input  logic [PID_W-1:0]  create_id,
  input  logic [PC_W-1:0]   create_pc,
  output logic              switch_req,
  output logic [PC_W-1:0]   restore_pc,
  output logic [PID_W-1:0]  cur_pid,
  output logic [PC_W-1:0]   base_addr,
  output logic [QCNT_W-1:0] quantum_left,
  output logic              idle,
  output logic              create_err
`ifdef SCHED_SWITCH_COUNT_EN
  ,
  output logic [15:0]       switch_count,
  output logic [15:0]       preempt_count
`endif
);

  localparam logic [QCNT_W-1:0] QFULL = QCNT_W'(QUANTUM);
  localparam logic [QCNT_W-1:0] QLAST = QCNT_W'(QUANTUM - 1);

  fsmStateT          fsm;
  slotStateT         slotState [NPROC];
  logic [PC_W-1:0]   savedPc   [NPROC];
  evTypeT            evType;
  logic [QCNT_W-1:0] count;
  logic [PID_W-1:0]  selStart;

  logic              createOk;
  logic [NPROC-1:0]  readyNow;
  logic [NPROC-1:0]  readyEff;
  logic [NPROC-1:0]  pickMask;
  logic              pickFound;
  logic [PID_W-1:0]  pickIdx;
  logic [PC_W-1:0]   dispPc;

  // readyEff folds in this cycle's io_done and accepted create so IDLE can
  // dispatch them on the very next edge.
  always_comb begin
    createOk = 1'b0;
    readyNow = '0;
    readyEff = '0;
    for (int i = 0; i < NPROC; i++) begin
      if (proc_create && create_id == PID_W'(i) && slotState[i] == FREE) createOk = 1'b1;
    end
    for (int i = 0; i < NPROC; i++) begin
      readyNow[i] = (slotState[i] == READY);
      readyEff[i] = readyNow[i] || (slotState[i] == BLOCKED && io_done[i]) ||
                    (createOk && create_id == PID_W'(i));
    end
    pickMask = (fsm == IDLE) ? readyEff : readyNow;
    dispPc   = (createOk && create_id == pickIdx) ? create_pc : savedPc[pickIdx];
  end

  rr_picker #(.NPROC(NPROC), .PID_W(PID_W)) picker (
    .readyMask (pickMask),
    .start     (selStart),
    .found     (pickFound),
    .index     (pickIdx)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      fsm          <= OFF;
      evType       <= EV_END;
      count        <= '0;
      selStart     <= '0;
      cur_pid      <= '0;
      switch_req   <= 1'b0;
      restore_pc   <= '0;
      base_addr    <= '0;
      quantum_left <= QFULL;
      idle         <= 1'b0;
      create_err   <= 1'b0;
      for (int i = 0; i < NPROC; i++) begin
        slotState[i] <= FREE;
        savedPc[i]   <= '0;
      end
`ifdef SCHED_SWITCH_COUNT_EN
      switch_count  <= '0;
      preempt_count <= '0;
`endif
    end else begin
      switch_req <= 1'b0;
      create_err <= proc_create && !createOk;
      for (int i = 0; i < NPROC; i++) begin
        if (slotState[i] == BLOCKED && io_done[i]) slotState[i] <= READY;
      end
      if (createOk) begin
        slotState[create_id] <= READY;
        savedPc[create_id]   <= create_pc;
      end

      case (fsm)
        OFF: begin
          if (enable) begin
            selStart <= '0;
            fsm      <= SELECT;
          end
        end
        RUN: begin
          if (step) begin
            count        <= count + 1'b1;
            quantum_left <= QFULL - count - QCNT_W'(1);
            if (proc_end || io_req || count == QLAST) begin
              savedPc[cur_pid] <= pc;
              evType <= proc_end ? EV_END : (io_req ? EV_IO : EV_QUANTUM);
              fsm    <= SAVE;
`ifdef SCHED_SWITCH_COUNT_EN
              if (!proc_end && !io_req && preempt_count != 16'hFFFF)
                preempt_count <= preempt_count + 1'b1;
`endif
            end
          end
        end
        SAVE: begin
          case (evType)
            EV_END:  slotState[cur_pid] <= FREE;
            EV_IO:   slotState[cur_pid] <= io_done[cur_pid] ? READY : BLOCKED;
            default: slotState[cur_pid] <= READY;
          endcase
          selStart <= (cur_pid == PID_W'(NPROC - 1)) ? '0 : cur_pid + 1'b1;
          fsm      <= SELECT;
        end
        SELECT, IDLE: begin
          if (pickFound) begin
            switch_req         <= 1'b1;
            restore_pc         <= dispPc;
            cur_pid            <= pickIdx;
            base_addr          <= PC_W'(pickIdx) * PC_W'(BASE_STRIDE);
            slotState[pickIdx] <= RUNNING;
            count              <= '0;
            quantum_left       <= QFULL;
            idle               <= 1'b0;
            fsm                <= DISPATCH;
          end else begin
            idle <= 1'b1;
            fsm  <= IDLE;
          end
        end
        DISPATCH: begin
          fsm <= RUN;
`ifdef SCHED_SWITCH_COUNT_EN
          if (switch_count != 16'hFFFF) switch_count <= switch_count + 1'b1;
`endif
        end
        default: fsm <= OFF;
      endcase
    end
  end

endmodule
